state_report_tx: RTL and testbench

STATE_REPORT_TX -- requirements
Module: state_report_tx

---
 rtl/state_report_tx.sv | 181 ++++++++++++++++++
 tb/tb_state_report_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/state_report_tx.sv
`default_nettype none
// ============================================================================
//  Module      : state_report_tx
//  Description : Sends a 4-byte UART frame (HEADER, LED/state, weight,
//                checksum) whenever the spirometer state or LED level changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module state_report_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic [2:0] ivState,
    input  logic [7:0] ivPeso,
    input  logic [2:0] ivLED,
    output logic       oTx,
    output logic       oBusy,
    output logic       oFrame_Done
);

    localparam int                    c_BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0]   c_BAUD_MAX = c_BAUD_W'(CLKS_PER_BIT - 1);

    // NEXT is the single closing cycle after the last stop bit has been
    // scheduled; it hands control back to IDLE and raises the done pulse.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        NEXT  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [c_BAUD_W-1:0]   r_baudCnt;
    logic [c_BAUD_W-1:0]   w_nextBaud;
    logic [2:0]            r_bitCnt;
    logic [2:0]            w_nextBit;
    logic [1:0]            r_byteIdx;
    logic [1:0]            w_nextByte;
    logic [2:0]            r_frmState;
    logic [7:0]            r_frmPeso;
    logic [2:0]            r_frmLed;
    logic [2:0]            rvLast_State;
    logic [2:0]            rvLast_LED;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_snap;
    logic                  w_txBit;
    logic                  w_change;
    logic                  w_baudWrap;
    logic [7:0]            w_statusByte;
    logic [7:0]            w_curByte;

    assign w_change     = (ivState != rvLast_State) || (ivLED != rvLast_LED);
    assign w_baudWrap   = (r_baudCnt == c_BAUD_MAX);
    assign w_statusByte = {r_frmLed, 2'b00, r_frmState};

    assign oTx          = r_tx;
    assign oBusy        = r_busy;
    assign oFrame_Done  = r_done;

    // Select the frame byte currently being shifted, all from the snapshot.
    always_comb begin
        w_curByte = HEADER;
        case (r_byteIdx)
            2'd0:    w_curByte = HEADER;
            2'd1:    w_curByte = w_statusByte;
            2'd2:    w_curByte = r_frmPeso;
            default: w_curByte = w_statusByte ^ r_frmPeso;
        endcase
    end

    // Next-state, counter and serial-bit decode.
    always_comb begin
        w_nextState = r_state;
        w_nextBaud  = r_baudCnt;
        w_nextBit   = r_bitCnt;
        w_nextByte  = r_byteIdx;
        w_snap      = 1'b0;
        w_txBit     = 1'b1;
        case (r_state)
            IDLE: begin
                w_nextBaud = '0;
                w_nextBit  = 3'd0;
                w_nextByte = 2'd0;
                if (w_change) begin
                    w_snap      = 1'b1;
                    w_nextState = START;
                end
            end
            START: begin
                w_txBit = 1'b0;
                if (w_baudWrap) begin
                    w_nextBaud  = '0;
                    w_nextBit   = 3'd0;
                    w_nextState = DATA;
                end else begin
                    w_nextBaud = r_baudCnt + c_BAUD_W'(1);
                end
            end
            DATA: begin
                w_txBit = w_curByte[r_bitCnt];
                if (w_baudWrap) begin
                    w_nextBaud = '0;
                    if (r_bitCnt == 3'd7) begin
                        w_nextBit   = 3'd0;
                        w_nextState = STOP;
                    end else begin
                        w_nextBit = r_bitCnt + 3'd1;
                    end
                end else begin
                    w_nextBaud = r_baudCnt + c_BAUD_W'(1);
                end
            end
            STOP: begin
                w_txBit = 1'b1;
                if (w_baudWrap) begin
                    w_nextBaud = '0;
                    if (r_byteIdx == 2'd3) begin
                        w_nextState = NEXT;
                    end else begin
                        // Straight into the next start bit: no idle gap.
                        w_nextByte  = r_byteIdx + 2'd1;
                        w_nextState = START;
                    end
                end else begin
                    w_nextBaud = r_baudCnt + c_BAUD_W'(1);
                end
            end
            NEXT: begin
                w_nextByte  = 2'd0;
                w_nextState = IDLE;
            end
            default: begin
                w_nextBaud  = '0;
                w_nextBit   = 3'd0;
                w_nextByte  = 2'd0;
                w_nextState = IDLE;
            end
        endcase
    end

    // State, counters, snapshot and registered line outputs.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state      <= IDLE;
            r_baudCnt    <= '0;
            r_bitCnt     <= 3'd0;
            r_byteIdx    <= 2'd0;
            r_frmState   <= 3'd0;
            r_frmPeso    <= 8'd0;
            r_frmLed     <= 3'd0;
            rvLast_State <= 3'd0;
            rvLast_LED   <= 3'd0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_baudCnt <= w_nextBaud;
            r_bitCnt  <= w_nextBit;
            r_byteIdx <= w_nextByte;
            r_tx      <= w_txBit;
            r_busy    <= (w_nextState != IDLE);
            r_done    <= (r_state == NEXT);
            if (w_snap) begin
                r_frmState   <= ivState;
                r_frmPeso    <= ivPeso;
                r_frmLed     <= ivLED;
                rvLast_State <= ivState;
                rvLast_LED   <= ivLED;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_state_report_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_state_report_tx
//  Description : Randomized scoreboard bench for state_report_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_state_report_tx;

    localparam int c_CPB   = 4;
    localparam int c_FLEN  = 40 * c_CPB;

    logic       iClk;
    logic       iReset_n;
    logic [2:0] ivState;
    logic [7:0] ivPeso;
    logic [2:0] ivLED;
    logic       oTx;
    logic       oBusy;
    logic       oFrame_Done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] b[4];
    } frame_t;

    frame_t expQ[$];
    int     startQ[$];
    int     doneQ[$];
    bit     monBusy = 1'b0;

    state_report_tx #(
        .CLKS_PER_BIT (c_CPB),
        .HEADER       (8'hA5)
    ) dut (
        .iClk        (iClk),
        .iReset_n    (iReset_n),
        .ivState     (ivState),
        .ivPeso      (ivPeso),
        .ivLED       (ivLED),
        .oTx         (oTx),
        .oBusy       (oBusy),
        .oFrame_Done (oFrame_Done)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is reported when (state, LED) differs from the
    // last reported pair and the transmitter is free; a frame keeps it busy for
    // the frame length plus the done cycle.
    initial begin
        logic [2:0] lastS;
        logic [2:0] lastL;
        int         freeIn;
        frame_t     f;
        lastS = 3'd0; lastL = 3'd0; freeIn = 0;
        forever begin
            @(posedge iClk or negedge iReset_n);
            if (!iReset_n) begin
                lastS = 3'd0; lastL = 3'd0; freeIn = 0;
                expQ.delete();
            end else if (freeIn == 0 && (ivState != lastS || ivLED != lastL)) begin
                f.b[0] = 8'hA5;
                f.b[1] = {ivLED, 2'b00, ivState};
                f.b[2] = ivPeso;
                f.b[3] = f.b[1] ^ f.b[2];
                expQ.push_back(f);
                lastS  = ivState;
                lastL  = ivLED;
                freeIn = c_FLEN + 1;
            end else if (freeIn > 0) begin
                freeIn--;
            end
        end
    end

    // Monitor: captures each frame's oTx waveform and compares to the model.
    initial begin
        bit     collecting;
        int     phase;
        int     idx;
        logic   p1;
        logic   p2;
        logic   got[c_FLEN];
        logic   want[c_FLEN];
        frame_t f;
        int     firstBad;
        logic [7:0] dec;
        collecting = 1'b0; phase = 0; idx = 0; p1 = 1'b0; p2 = 1'b0;
        forever begin
            @(negedge iClk);
            if (!iReset_n) begin
                collecting = 1'b0; phase = 0; monBusy = 1'b0; p1 = 1'b0; p2 = 1'b0;
                continue;
            end
            if (collecting) begin
                got[idx] = oTx;
                idx++;
                if (idx == c_FLEN) begin
                    firstBad = 9999;
                    for (int i = c_FLEN - 1; i >= 0; i--)
                        if (got[i] !== want[i]) firstBad = i;
                    chk("frame_waveform_first_bad_sample", firstBad, 9999);
                    for (int b = 0; b < 4; b++) begin
                        for (int k = 0; k < 8; k++)
                            dec[k] = got[(b * 10 + k + 1) * c_CPB + c_CPB / 2];
                        chk($sformatf("frame_byte%0d", b), {24'd0, dec}, {24'd0, f.b[b]});
                    end
                    collecting = 1'b0;
                    phase = 1;
                end
            end else if (phase == 1) begin
                chk("done_pulse_high", {29'd0, oFrame_Done, oBusy, oTx}, 32'h5);
                doneQ.push_back(cyc);
                phase = 2;
            end else if (phase == 2) begin
                chk("done_pulse_one_cycle", {31'd0, oFrame_Done}, 32'd0);
                phase = 0;
                monBusy = 1'b0;
            end else if (oTx == 1'b0) begin
                monBusy = 1'b1;
                if (expQ.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame: got start bit expected idle line (cyc %0d)", cyc);
                    f.b[0] = 8'h00; f.b[1] = 8'h00; f.b[2] = 8'h00; f.b[3] = 8'h00;
                end else begin
                    f = expQ.pop_front();
                end
                chk("busy_one_cycle_before_start", {30'd0, p2, p1}, 32'd1);
                for (int b = 0; b < 4; b++)
                    for (int k = 0; k < 10; k++)
                        for (int r = 0; r < c_CPB; r++)
                            want[(b * 10 + k) * c_CPB + r] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : f.b[b][k-1];
                startQ.push_back(cyc);
                got[0] = oTx;
                idx = 1;
                collecting = 1'b1;
            end
            p2 = p1;
            p1 = oBusy;
        end
    end

    task automatic waitIdle(input string tag);
        int n;
        repeat (3) @(negedge iClk);
        n = 0;
        while ((expQ.size() != 0 || monBusy) && n < 3000) begin
            @(negedge iClk);
            n++;
        end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s_timeout: got still busy expected idle within 3000 cycles", tag);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int chg;
        int n0;
        bit anyAct;
        iReset_n = 1'b0; ivState = 3'd0; ivLED = 3'd0; ivPeso = 8'h46;
        repeat (3) @(negedge iClk);
        chk("reset_outputs", {29'd0, oTx, oBusy, oFrame_Done}, 32'h4);
        iReset_n = 1'b1;
        repeat (5) @(negedge iClk);
        chk("idle_after_reset", {29'd0, oTx, oBusy, oFrame_Done}, 32'h4);

        // Basic frame: state 0 -> 1, expected A5 01 46 47.
        ivState = 3'd1;
        chg = cyc;
        waitIdle("basic");
        chk("first_start_latency", startQ[startQ.size()-1], chg + 2);
        chk("frame_length", doneQ[doneQ.size()-1] - startQ[startQ.size()-1], c_FLEN);

        // LED-triggered frame.
        ivPeso = 8'($urandom);
        ivLED  = 3'd3;
        waitIdle("led");

        // Change during busy: only the latest value is reported next.
        ivState = 3'd0; ivLED = 3'd0;
        waitIdle("pre_busy");
        n0 = startQ.size();
        ivState = 3'd1;
        repeat (30) @(negedge iClk);
        ivState = 3'd2;
        repeat (40) @(negedge iClk);
        ivState = 3'd3;
        waitIdle("busy_change");
        chk("busy_change_frame_count", startQ.size() - n0, 2);
        chk("back_to_back_start", startQ[startQ.size()-1], doneQ[doneQ.size()-2] + 2);

        // Weight-only changes never start a frame.
        anyAct = 1'b0;
        for (int i = 0; i < 200; i++) begin
            ivPeso = 8'($urandom);
            @(negedge iClk);
            if (oTx !== 1'b1 || oBusy !== 1'b0) anyAct = 1'b1;
        end
        chk("weight_only_no_activity", {31'd0, anyAct}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 10; i++) begin
            ivState = 3'($urandom_range(0, 4));
            ivLED   = 3'($urandom);
            ivPeso  = 8'($urandom);
            repeat ($urandom_range(0, 250)) @(negedge iClk);
        end
        waitIdle("random");

        // Reset in the middle of byte 2.
        ivState = 3'd0; ivLED = 3'd0;
        waitIdle("pre_reset");
        ivState = 3'd4; ivPeso = 8'h3C;
        n0 = 0;
        while (!monBusy && n0 < 100) begin
            @(negedge iClk);
            n0++;
        end
        chk("reset_test_frame_started", {31'd0, monBusy}, 32'd1);
        repeat (2 * 10 * c_CPB + 10) @(posedge iClk);
        #2 iReset_n = 1'b0;
        #1 chk("async_reset_outputs", {29'd0, oTx, oBusy, oFrame_Done}, 32'h4);
        ivState = 3'd2;
        repeat (3) @(negedge iClk);
        n0 = startQ.size();
        iReset_n = 1'b1;
        waitIdle("after_reset");
        chk("after_reset_frame_count", startQ.size() - n0, 1);

        chk("scoreboard_empty", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
